// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
//
// Purpose : Shared types and constants for the accum_4bit block.
//
// Contents:
//   DATA_W  - width of operands and of the accumulated sum (4)
//   CNT_W   - width of the accepted-operand counter (3)
//   state_t - controller states:
//               IDLE  : no operand accepted yet for the current sum
//               ACCUM : some, but not all, operands accepted
//               DONE  : result complete and held until consumed
// -----------------------------------------------------------------------------
package accum_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : accum_pkg

// File: rtl/adder_4bit.sv
// -----------------------------------------------------------------------------
// adder_4bit
//
// Purpose : Plain 4-bit ripple-style adder with carry in and carry out.
//
// Ports:
//   a    in  [3:0]  first addend
//   b    in  [3:0]  second addend
//   cin  in         carry in
//   sum  out [3:0]  a + b + cin, modulo 16
//   cout out        carry out of bit 3
// -----------------------------------------------------------------------------
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Widen every operand to 5 bits so the carry lands in the top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule : adder_4bit

// File: rtl/accum_4bit.sv
// -----------------------------------------------------------------------------
// accum_4bit
//
// Purpose : Sums N_OPS unsigned 4-bit operands accepted over a valid/ready
//           input handshake and presents the result over a valid/ready output
//           handshake. A sticky overflow flag records any carry out of bit 3.
//
// Parameters:
//   N_OPS      operands summed per result, legal range 1..7 (default 4)
//
// Ports:
//   clk        in         single clock, rising edge
//   rst_n      in         asynchronous active-low reset
//   clear      in         synchronous abort of the current sum (top priority)
//   in_valid   in         operand on din is valid
//   in_ready   out        operand is accepted this cycle if in_valid is high
//   din        in  [3:0]  unsigned operand
//   out_valid  out        result on acc is valid
//   out_ready  in         consumer takes the result this cycle
//   acc        out [3:0]  running or final sum
//   ovf        out        sticky carry-out flag for the current sum
//   count      out [2:0]  operands accepted for the current sum
//
// Build option:
//   ACCUM_SAT_EN  when defined, a carry saturates acc at 4'hF until the result
//                 is consumed; otherwise acc wraps modulo 16. ovf is set in
//                 both builds.
// -----------------------------------------------------------------------------
module accum_4bit
  import accum_pkg::*;
#(
  parameter int N_OPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc,
  output logic              ovf,
  output logic [CNT_W-1:0]  count
);

  // Count value at which the sum is complete.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_OPS);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q,   acc_d;
  logic                ovf_q,   ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [DATA_W-1:0]   add_sum;
  logic                add_carry;
  logic [CNT_W-1:0]    count_inc;
  logic                accept;
  logic                take_result;

  // Single shared adder: running sum plus incoming operand, no carry in.
  adder_4bit u_adder (
    .a    (acc_q),
    .b    (din),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_carry)
  );

  assign in_ready    = (state_q != DONE) && !clear;
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid && in_ready;
  assign take_result = out_valid && out_ready && !clear;
  assign count_inc   = count_q + 3'd1;

  assign acc   = acc_q;
  assign ovf   = ovf_q;
  assign count = count_q;

  // Next-state and datapath update. Clear beats both handshakes; consuming a
  // result returns to IDLE without accepting an operand on the same edge
  // (in_ready is low in DONE, so that falls out naturally).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            count_d = count_inc;
            ovf_d   = ovf_q | add_carry;
`ifdef ACCUM_SAT_EN
            // Once saturated, stay pinned at full scale until consumed.
            acc_d   = (add_carry || ovf_q) ? 4'hF : add_sum;
`else
            acc_d   = add_sum;
`endif
            state_d = (count_inc == LAST_COUNT) ? DONE : ACCUM;
          end
        end

        DONE: begin
          if (take_result) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
          end
        end

        default: begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any partial or held sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

endmodule : accum_4bit

// File: tb/tb_accum_4bit.sv
// -----------------------------------------------------------------------------
// tb_accum_4bit
//
// Drives two accumulators (N_OPS=4 and N_OPS=1) from the same stimulus and
// checks them every cycle against a sum-of-operands model, plus directed
// literal expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_accum_4bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [3:0] din;
   logic       out_ready;

   logic       in_ready4, out_valid4, ovf4;
   logic [3:0] acc4;
   logic [2:0] count4;
   logic       in_ready1, out_valid1, ovf1;
   logic [3:0] acc1;
   logic [2:0] count1;

   int nChecks = 0;
   int nPass   = 0;
   bit chkEn   = 1'b0;

   // Model state per instance: true (unbounded) total of accepted operands,
   // number accepted, and whether the result is complete.
   int nOps[2]   = '{4, 1};
   int mTotal[2] = '{0, 0};
   int mCnt[2]   = '{0, 0};
   bit mDone[2]  = '{1'b0, 1'b0};

   accum_4bit #(.N_OPS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready4), .din(din), .out_valid(out_valid4),
      .out_ready(out_ready), .acc(acc4), .ovf(ovf4), .count(count4)
   );

   accum_4bit #(.N_OPS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready1), .din(din), .out_valid(out_valid1),
      .out_ready(out_ready), .acc(acc1), .ovf(ovf1), .count(count1)
   );

   always #5 clk = ~clk;

   // A carry out of bit 3 has happened exactly when the true total reached 16.
   function automatic int expAcc(input int total);
`ifdef ACCUM_SAT_EN
      return (total >= 16) ? 15 : total;
`else
      return total % 16;
`endif
   endfunction

   function automatic int expOvf(input int total);
      return (total >= 16) ? 1 : 0;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act == exp) nPass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] d,
                                input logic c, input logic r);
      in_valid  = v;
      din       = d;
      clear     = c;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   // Reference model: advances on each clock edge from the inputs in force.
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n || clear || (mDone[k] && out_ready)) begin
            mTotal[k] <= 0;
            mCnt[k]   <= 0;
            mDone[k]  <= 1'b0;
         end else if (!mDone[k] && in_valid) begin
            mTotal[k] <= mTotal[k] + int'(din);
            mCnt[k]   <= mCnt[k] + 1;
            mDone[k]  <= (mCnt[k] + 1 == nOps[k]);
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("acc4",       int'(acc4),       expAcc(mTotal[0]));
         checkOutput("ovf4",       int'(ovf4),       expOvf(mTotal[0]));
         checkOutput("count4",     int'(count4),     mCnt[0]);
         checkOutput("out_valid4", int'(out_valid4), int'(mDone[0]));
         checkOutput("in_ready4",  int'(in_ready4),  int'(!mDone[0] && !clear));
         checkOutput("acc1",       int'(acc1),       expAcc(mTotal[1]));
         checkOutput("ovf1",       int'(ovf1),       expOvf(mTotal[1]));
         checkOutput("count1",     int'(count1),     mCnt[1]);
         checkOutput("out_valid1", int'(out_valid1), int'(mDone[1]));
         checkOutput("in_ready1",  int'(in_ready1),  int'(!mDone[1] && !clear));
      end
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; din = 4'h0; out_ready = 1'b0;
      #2;
      checkOutput("rst_acc",       int'(acc4),       0);
      checkOutput("rst_count",     int'(count4),     0);
      checkOutput("rst_ovf",       int'(ovf4),       0);
      checkOutput("rst_out_valid", int'(out_valid4), 0);
      checkOutput("rst_in_ready",  int'(in_ready4),  1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chkEn = 1'b1;

      // Four back-to-back operands with the consumer ready.
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b1);
      checkOutput("b2b_count3",    int'(count4),     3);
      checkOutput("b2b_ov_early",  int'(out_valid4), 0);
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checkOutput("b2b_out_valid", int'(out_valid4), 1);
      checkOutput("b2b_acc",       int'(acc4),       10);
      checkOutput("b2b_ovf",       int'(ovf4),       0);
      checkOutput("b2b_count",     int'(count4),     4);

      // Held result while the consumer stalls.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
         checkOutput("hold_acc",       int'(acc4),       10);
         checkOutput("hold_out_valid", int'(out_valid4), 1);
         checkOutput("hold_in_ready",  int'(in_ready4),  0);
      end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      checkOutput("take_out_valid", int'(out_valid4), 0);
      checkOutput("take_acc",       int'(acc4),       0);
      checkOutput("take_in_ready",  int'(in_ready4),  1);

      // Overflow: 8+8+0+0.
      applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
`ifdef ACCUM_SAT_EN
      checkOutput("ovfl_acc", int'(acc4), 15);
`else
      checkOutput("ovfl_acc", int'(acc4), 0);
`endif
      checkOutput("ovfl_ovf",       int'(ovf4),       1);
      checkOutput("ovfl_out_valid", int'(out_valid4), 1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

      // Clear beats an offered operand after two accepts.
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
      checkOutput("clr_pre_count", int'(count4), 2);
      applyStimulus(1'b1, 4'd9, 1'b1, 1'b0);
      checkOutput("clr_acc",      int'(acc4),      0);
      checkOutput("clr_count",    int'(count4),    0);
      checkOutput("clr_in_ready", int'(in_ready4), 0);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a sum.
      applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("arst_acc",       int'(acc4),       0);
      checkOutput("arst_count",     int'(count4),     0);
      checkOutput("arst_ovf",       int'(ovf4),       0);
      checkOutput("arst_out_valid", int'(out_valid4), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
`ifdef ACCUM_SAT_EN
      checkOutput("arst_new_acc", int'(acc4), 15);
`else
      checkOutput("arst_new_acc", int'(acc4), 4);
`endif
      checkOutput("arst_new_ovf",   int'(ovf4),   1);
      checkOutput("arst_new_count", int'(count4), 4);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

      // Single-operand instance.
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
      in_valid = 1'b0;
      checkOutput("n1_acc",       int'(acc1),       7);
      checkOutput("n1_ovf",       int'(ovf1),       0);
      checkOutput("n1_out_valid", int'(out_valid1), 1);
      checkOutput("n1_count",     int'(count1),     1);
      checkOutput("n1_in_ready",  int'(in_ready1),  0);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);

      // Randomized traffic with occasional clears and mid-cycle resets.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 3) != 0,
                       4'($urandom_range(0, 15)),
                       $urandom_range(0, 24) == 0,
                       $urandom_range(0, 1) == 1);
         if (i % 150 == 75) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end

      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      chkEn = 1'b0;
      #1;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule : tb_accum_4bit
